// File: rtl/signed_int_to_float_seq_if.sv
// Valid/ready handshake bundle for the int-to-float converter: operand in, IEEE-754 single out.
interface signed_int_to_float_seq_if;
  logic [31:0] signed_int_val;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] FP_val;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output signed_int_val,
    output in_valid,
    input  in_ready,
    input  FP_val,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  signed_int_val,
    input  in_valid,
    output in_ready,
    output FP_val,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/signed_int_to_float_seq.sv
// Sequential 32-bit signed integer to IEEE-754 single converter, one normalising shift per cycle.
// Optional INT2FP_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates toward zero.
module signed_int_to_float_seq (
  input  logic                      clk,
  input  logic                      rst,
  signed_int_to_float_seq_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, NORM, PACK, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] sh_reg, sh_next;
  logic [4:0]  cnt_reg, cnt_next;
  logic        sign_reg, sign_next;
  logic [31:0] fp_reg, fp_next;

  logic [7:0]  exp_raw;
  logic [30:0] mag_trunc;
  logic [30:0] mag_packed;

  // Exponent and mantissa travel as one 31-bit field so a rounding carry ripples into the exponent.
  assign exp_raw   = 8'd158 - {3'b000, cnt_reg};
  assign mag_trunc = {exp_raw, sh_reg[30:8]};

`ifdef INT2FP_ROUND_NEAREST_EN
  logic guard_bit, sticky_bit, round_up;
  assign guard_bit  = sh_reg[7];
  assign sticky_bit = |sh_reg[6:0];
  assign round_up   = guard_bit & (sticky_bit | sh_reg[8]);
  assign mag_packed = mag_trunc + {30'd0, round_up};
`else
  assign mag_packed = mag_trunc;
`endif

  always_comb begin
    state_next = state_reg;
    sh_next    = sh_reg;
    cnt_next   = cnt_reg;
    sign_next  = sign_reg;
    fp_next    = fp_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          sign_next  = bus.signed_int_val[31];
          // Negating -2^31 wraps back to 0x80000000, which is the correct magnitude unsigned.
          sh_next    = bus.signed_int_val[31] ? (~bus.signed_int_val + 32'd1)
                                              : bus.signed_int_val;
          cnt_next   = '0;
          state_next = NORM;
        end
      end
      NORM: begin
        if (sh_reg[31] || (sh_reg == 32'd0)) begin
          state_next = PACK;
        end else begin
          sh_next  = sh_reg << 1;
          cnt_next = cnt_reg + 5'd1;
        end
      end
      PACK: begin
        // Zero always packs as +0 regardless of the captured sign.
        fp_next    = (sh_reg == 32'd0) ? 32'd0 : {sign_reg, mag_packed};
        state_next = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sh_reg    <= '0;
      cnt_reg   <= '0;
      sign_reg  <= 1'b0;
      fp_reg    <= '0;
    end else begin
      state_reg <= state_next;
      sh_reg    <= sh_next;
      cnt_reg   <= cnt_next;
      sign_reg  <= sign_next;
      fp_reg    <= fp_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.FP_val    = fp_reg;
endmodule

// File: tb/tb_signed_int_to_float_seq.sv
// Self-checking bench: directed vector table, hand-written hold/reset sequences, randomized model check.
module tb_signed_int_to_float_seq;
  logic clk;
  logic rst;
  signed_int_to_float_seq_if bus ();

  signed_int_to_float_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] x;
    logic [31:0] exp_trunc;
    logic [31:0] exp_rne;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: locate the leading one, then divide down to 24 significant bits and round on the remainder.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint m, q, rem, half;
    int     e, s;
    logic [7:0] e8;
    logic [31:0] r;
    m = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) return 32'd0;
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    if (e <= 23) begin
      q = m << (23 - e);
    end else begin
      s    = e - 23;
      q    = m >> s;
      rem  = m - (q << s);
      half = longint'(1) << (s - 1);
`ifdef INT2FP_ROUND_NEAREST_EN
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == (longint'(1) << 24)) begin
        q = longint'(1) << 23;
        e = e + 1;
      end
`else
      if (rem > half) q = q; // truncation ignores the remainder
`endif
    end
    e8 = 8'(127 + e);
    r  = {x[31], e8, q[22:0]};
    return r;
  endfunction

  function automatic int ref_lat(input logic [31:0] x);
    longint m;
    int e;
    m = longint'($signed(x));
    if (m < 0) m = -m;
    if (m == 0) return 2;
    e = 0;
    for (int i = 0; i < 32; i++) if (m[i]) e = i;
    return 2 + (31 - e);
  endfunction

  // Called 1 time unit after a rising edge with the converter idle; returns in IDLE after consuming.
  task automatic conv(input logic [31:0] x, output logic [31:0] got, output int lat);
    check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    bus.signed_int_val = x;
    bus.in_valid       = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid       = 1'b0;
    bus.signed_int_val = $urandom;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.out_valid && lat < 100);
    got = bus.FP_val;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    $display("conv %h -> %h after %0d edges", x, got, lat);
  endtask

  vec_t vecs[$];
  logic [31:0] got, x, exp;
  int lat, seen;

  initial begin
    vecs.push_back('{"one",       32'h00000001, 32'h3F800000, 32'h3F800000, 33});
    vecs.push_back('{"minus_one", 32'hFFFFFFFF, 32'hBF800000, 32'hBF800000, 33});
    vecs.push_back('{"zero",      32'h00000000, 32'h00000000, 32'h00000000, 2});
    vecs.push_back('{"int_min",   32'h80000000, 32'hCF000000, 32'hCF000000, 2});
    vecs.push_back('{"int_max",   32'h7FFFFFFF, 32'h4EFFFFFF, 32'h4F000000, 3});
    vecs.push_back('{"round_up",  32'h01000003, 32'h4B800001, 32'h4B800002, 9});
    vecs.push_back('{"tie_even",  32'h01000001, 32'h4B800000, 32'h4B800000, 9});
    vecs.push_back('{"three",     32'h00000003, 32'h40400000, 32'h40400000, 32});
    vecs.push_back('{"minus_5",   32'hFFFFFFFB, 32'hC0A00000, 32'hC0A00000, 31});

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.signed_int_val = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_fp_val", bus.FP_val, 32'd0);

    foreach (vecs[i]) begin
`ifdef INT2FP_ROUND_NEAREST_EN
      exp = vecs[i].exp_rne;
`else
      exp = vecs[i].exp_trunc;
`endif
      conv(vecs[i].x, got, lat);
      check({vecs[i].name, "_value"}, got, exp);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
    end

    // Back-pressure: result held, converter busy, stray operand ignored.
    bus.signed_int_val = 32'd3;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd32);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin
        bus.signed_int_val = 32'd5;
        bus.in_valid = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("hold_fp_val", bus.FP_val, 32'h40400000);
      check("hold_out_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("after_hold_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_hold_out_valid", 32'(bus.out_valid), 32'd0);
    conv(32'd7, got, lat);
    check("after_hold_next_value", got, 32'h40E00000);
    check("after_hold_next_latency", 32'(lat), 32'd31);

    // Reset mid-conversion discards the operation; in_valid alongside rst is ignored.
    bus.signed_int_val = 32'd1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.signed_int_val = 32'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("mid_reset_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_reset_fp_val", bus.FP_val, 32'd0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      #1;
    end
    check("mid_reset_no_out_valid", 32'(seen), 32'd0);
    conv(32'd2, got, lat);
    check("post_reset_value", got, 32'h40000000);
    check("post_reset_latency", 32'(lat), 32'd32);

    // Randomized magnitudes spread across all leading-zero counts.
    for (int t = 0; t < 150; t++) begin
      x = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      conv(x, got, lat);
      check("rand_value", got, ref_fp(x));
      check("rand_latency", 32'(lat), 32'(ref_lat(x)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/signed_int_to_float_seq.md
# signed_int_to_float_seq

Sequential converter from a 32-bit two's-complement integer to an IEEE-754 single-precision float. It is the inverse path of the float-to-signed-int converter in the FP module set. It normalizes with one left shift per cycle, which keeps the combinational depth out of the datapath critical path. It sits between integer producers (accumulators, counters, pixel sums) and the FP arithmetic units, using a valid/ready handshake on both sides.

## Interface
- No parameters; widths are fixed at 32-bit integer in and 32-bit float out.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- signed_int_val  input  32  signed integer operand; sampled on acceptance.
- in_valid  input  1  operand present.
- in_ready  output  1  converter idle and able to accept.
- FP_val  output  32  IEEE-754 result {sign, exponent[7:0], mantissa[22:0]}.
- out_valid  output  1  FP_val holds a completed result.
- out_ready  input  1  consumer takes the result.

## Operation
- States are IDLE, NORM, PACK and DONE; the reset state is IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready: register sign = signed_int_val[31].
  - Register a 32-bit shift register sh = |signed_int_val| (unsigned). -2^31 yields 0x80000000.
  - Clear the 5-bit shift counter; go to NORM.
- **NORM**
  - If sh[31] = 1 or sh = 0: go to PACK.
  - Otherwise: sh <= sh << 1, cnt <= cnt + 1, stay in NORM.
- **PACK**
  - Zero input (sh = 0): result = 0x00000000. Always +0, never -0.
  - Otherwise: exponent = 8'd158 - cnt, i.e. 127 + 31 - cnt.
  - Mantissa = sh[30:8]. The guard bit is sh[7]; the sticky bit is |sh[6:0].
  - Rounding follows the Configuration section. Register FP_val; go to DONE.
- **DONE**
  - out_valid = 1, and FP_val is held stable.
  - On out_ready: go to IDLE. out_valid is low in IDLE.
- Only one conversion is in flight at a time. in_ready = 0 in NORM, PACK and DONE.
- Exponent range is 127..158, so denormals, infinities and NaNs are never produced.

## Timing
- Reset values: in_ready = 1 after the reset edge, out_valid = 0, FP_val = 0x00000000, and internal sh, cnt and sign are cleared.
- Latency: out_valid rises 2 + lz rising edges after the accepting edge. lz is the count of leading zeros of |x|, range 0..31; a zero input takes 2 edges.
  - Minimum latency is 2 edges, for |x| ≥ 2^31 and for zero.
  - Maximum latency is 33 edges, for ±1.
- Back-to-back: the result is consumed on edge N, IDLE is entered, and the next operand can be accepted on edge N+1. The converter issues at most one conversion per (latency + 2) edges.
- out_valid & !out_ready: FP_val and out_valid are held indefinitely.
- in_valid and signed_int_val are ignored outside IDLE. The operand is captured only on the accepting edge, so later changes to it have no effect.
- rst asserted in any state:
  - The next edge returns to IDLE with reset output values.
  - Any in-flight conversion is discarded, and no out_valid pulse is produced.
  - in_valid asserted together with rst is not accepted.

## Configuration
- Macro `INT2FP_ROUND_NEAREST_EN`.
- **Defined:** round-to-nearest-even in PACK.
  - Increment {exponent, mantissa} as one 31-bit value when guard & (sticky | mantissa[0]).
  - A mantissa carry-out naturally bumps the exponent and zeroes the mantissa.
- **Undefined:** truncation toward zero; guard and sticky are ignored. This matches the truncating behaviour of the float-to-int direction.
- Latency is identical in both builds.

## Test plan
- Reset, then 1 → FP_val = 0x3F800000, out_valid 33 edges after accept; -1 → 0xBF800000.
- 0 → 0x00000000 after 2 edges; -2^31 (0x80000000) → 0xCF000000 after 2 edges.
- 0x7FFFFFFF → 0x4EFFFFFF with the macro undefined; 0x4F000000 with it defined (carry into exponent).
- 0x01000003 → 0x4B800001 truncating; 0x4B800002 with RNE. 0x01000001 → 0x4B800000 in both builds (tie to even).
- Hold out_ready low for 10 cycles on result 0x40400000 (input 3):
  - FP_val and out_valid stay stable, and in_ready stays 0.
  - An in_valid pulse with operand 5 during the hold is not accepted.
  - After out_ready, the next operand is accepted one edge later.
- Assert rst while in NORM converting 1 → no out_valid ever appears. in_ready = 1 and FP_val = 0 on the next edge, and a following conversion of 2 → 0x40000000 completes normally.
